spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 3..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: minimum nCS-high clk cycles after a frame; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request to send one frame; sampled only when busy=0.
REQ-006 SHALL have port addr, input, 7: register address, captured on an accepted start.
REQ-007 SHALL have port data, input, 8: register write data, captured on an accepted start.
REQ-008 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at frame completion.
REQ-010 SHALL have port nCS, output, 1: active-low chip select.
REQ-011 SHALL have port SCLK, output, 1: serial clock, SPI mode 0, idle low.
REQ-012 SHALL have port COPI, output, 1: serial data, controller to peripheral.

Function
REQ-013 SHALL accept start only in IDLE (busy=0); start while busy=1 SHALL be ignored with no effect on the frame in flight.
REQ-014 SHALL, on acceptance, latch frame F = {1'b1, addr[6:0], data[7:0]} into a 16-bit shift register; later addr/data changes SHALL NOT affect the frame.
REQ-015 SHALL use states IDLE -> SETUP -> SHIFT_HI -> SHIFT_LO (x16) -> GAP -> IDLE.
REQ-016 SHALL, with acceptance at cycle 0, drive nCS=0, SCLK=0, COPI=F[15], busy=1 from cycle 1 (SETUP, CLK_DIV cycles).
REQ-017 SHALL drive SCLK high for CLK_DIV cycles (SHIFT_HI) then low for CLK_DIV cycles (SHIFT_LO), 16 times; exactly 16 rising SCLK edges per frame.
REQ-018 SHALL change COPI only in the cycle SCLK falls, presenting the next bit MSB first; COPI SHALL be stable throughout every SCLK-high phase.
REQ-019 SHALL treat the 16th SHIFT_LO phase as nCS hold; nCS SHALL stay low for exactly 33*CLK_DIV cycles (cycles 1..33*CLK_DIV).
REQ-020 SHALL drive nCS=1, SCLK=0, COPI=0 in GAP for exactly GAP_CYCLES cycles.
REQ-021 SHALL pulse done=1 and drive busy=0 in cycle 33*CLK_DIV+GAP_CYCLES+1 (the first IDLE cycle); start in that cycle SHALL be accepted.
REQ-022 SHALL use a half-period counter of width clog2(CLK_DIV+1) and a 4-bit bit counter, with no wrap beyond the 16th bit.
REQ-023 SHALL hold done=0 in every cycle except the completion cycle.
REQ-024 SHALL keep SCLK low whenever nCS=1, and SHALL NOT produce a glitch on SCLK or nCS (all outputs registered).

Reset
REQ-025 SHALL, while rst=1 at a clk edge, set nCS=1, SCLK=0, COPI=0, busy=0, done=0, state IDLE, counters and shift register 0.
REQ-026 SHALL abort a frame in progress on rst, without pulsing done; nCS SHALL rise no later than the edge where rst is sampled.
REQ-027 SHALL give rst priority over start in the same cycle.

Verification
REQ-028 SHALL be verified as follows: rst=1 for 2 cycles -> nCS=1, SCLK=0, COPI=0, busy=0, done=0.
REQ-029 SHALL be verified as follows: CLK_DIV=4, GAP_CYCLES=4, start with addr=0x04 and data=0xA5 -> bits at SCLK rises are 1,0000100,10100101; done is seen at cycle 137; with a receiving peripheral model attached, pwm_duty_cycle=0xA5.
REQ-030 SHALL be verified as follows: start with addr=0x01 and data=0x3C, then start again at cycle 20 with addr=0x02 and data=0xFF -> the second start is ignored, the frame carries 0x813C, and exactly one done occurs.
REQ-031 SHALL be verified as follows: start held high continuously -> consecutive frames run with nCS high for exactly GAP_CYCLES+1 cycles between them.
REQ-032 SHALL be verified as follows: rst pulsed for 1 cycle after the 7th rising SCLK edge -> next cycle nCS=1, SCLK=0, busy=0, with no done; a following frame with addr=0x00 and data=0x55 is received intact.
REQ-033 SHALL be verified as follows: corner frames with addr=0x7F/data=0x00 and addr=0x00/data=0xFF, and CLK_DIV=3 -> exact bit sequences, 16 rising edges, and COPI never changes while SCLK=1.

Source files
------------

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: sends one 16-bit frame {1, addr[6:0], data[7:0]}
// per accepted start, MSB first, then holds nCS high for a minimum gap.
// All outputs come straight from flops so nCS/SCLK cannot glitch.
module spi_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftHi,
    StShiftLo,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     shreg_q, shreg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ncs_q, ncs_d;
  logic            sclk_q, sclk_d;
  logic            copi_q, copi_d;

  // Sequencer: phase timing, bit count and frame shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          shreg_d = {1'b1, addr, data};
          cnt_d   = '0;
          gap_d   = '0;
          bit_d   = '0;
        end
      end
      StSetup: begin
        if (cnt_q == CntLast) begin
          state_d = StShiftHi;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShiftHi: begin
        if (cnt_q == CntLast) begin
          // Falling SCLK edge: the only place the next bit is presented.
          state_d = StShiftLo;
          cnt_d   = '0;
          shreg_d = {shreg_q[14:0], 1'b0};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShiftLo: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          // The 16th low phase doubles as nCS hold time.
          if (bit_q == 4'd15) begin
            state_d = StGap;
            gap_d   = '0;
          end else begin
            state_d = StShiftHi;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state.
  always_comb begin
    ncs_d  = 1'b1;
    sclk_d = 1'b0;
    copi_d = 1'b0;
    busy_d = 1'b0;
    unique case (state_d)
      StSetup, StShiftLo: begin
        ncs_d  = 1'b0;
        copi_d = shreg_d[15];
        busy_d = 1'b1;
      end
      StShiftHi: begin
        ncs_d  = 1'b0;
        sclk_d = 1'b1;
        copi_d = shreg_d[15];
        busy_d = 1'b1;
      end
      StGap: busy_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign nCS  = ncs_q;
  assign SCLK = sclk_q;
  assign COPI = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (CLK_DIV=4/GAP=4 and CLK_DIV=3/GAP=2) checked
// cycle by cycle against a frame-timing reference model plus a receiving peripheral.
module tb_spi_controller;

  localparam int unsigned K0 = 4;
  localparam int unsigned G0 = 4;
  localparam int unsigned K1 = 3;
  localparam int unsigned G1 = 2;

  logic       clk;
  logic       rst;
  logic [1:0] start;
  logic [6:0] addr_v [2];
  logic [7:0] data_v [2];
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] ncs;
  logic [1:0] sclk;
  logic [1:0] copi;

  int vectors;
  int miscompares;
  logic [7:0] pwm_duty_cycle;

  spi_controller #(.CLK_DIV(K0), .GAP_CYCLES(G0)) u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .start(start[0]),
    .addr (addr_v[0]),
    .data (data_v[0]),
    .busy (busy[0]),
    .done (done[0]),
    .nCS  (ncs[0]),
    .SCLK (sclk[0]),
    .COPI (copi[0])
  );

  spi_controller #(.CLK_DIV(K1), .GAP_CYCLES(G1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(start[1]),
    .addr (addr_v[1]),
    .data (data_v[1]),
    .busy (busy[1]),
    .done (done[1]),
    .nCS  (ncs[1]),
    .SCLK (sclk[1]),
    .COPI (copi[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected pins n cycles after acceptance: {copi_care, done, busy, ncs, sclk, copi}.
  function automatic logic [5:0] model(input int n, input int k, input int g,
                                       input logic [15:0] f);
    int p;
    int i;
    if (n <= 33 * k) begin
      p = (n - 1) / k;
      if (p == 0) return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, f[15]};
      i = (p - 1) / 2;
      if (((p - 1) % 2) == 0) return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, f[15-i]};
      if (i == 15) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, f[14-i]};
    end
    if (n <= 33 * k + g) return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic check_reset_pins(input int u, input string tag);
    check($sformatf("%s u%0d ncs", tag, u), ncs[u], 1);
    check($sformatf("%s u%0d sclk", tag, u), sclk[u], 0);
    check($sformatf("%s u%0d copi", tag, u), copi[u], 0);
    check($sformatf("%s u%0d busy", tag, u), busy[u], 0);
    check($sformatf("%s u%0d done", tag, u), done[u], 0);
  endtask

  // Called at the negedge of the acceptance cycle (cycle 0); returns at the negedge of the
  // done cycle. hold keeps start high throughout; noise wiggles start/addr/data while busy
  // (including a start at cycle 20); abort_rise>0 pulses rst after that many SCLK rises.
  task automatic run_frame(input int u, input logic [6:0] a, input logic [7:0] d,
                           input bit hold, input bit noise, input int abort_rise);
    int k;
    int g;
    int last;
    int rises;
    int dones;
    int done_at;
    logic [15:0] f;
    logic [15:0] rx;
    logic [5:0] e;
    logic prev;
    k = (u == 0) ? K0 : K1;
    g = (u == 0) ? G0 : G1;
    last = 33 * k + g + 1;
    f = {1'b1, a, d};
    rises = 0;
    dones = 0;
    done_at = 0;
    rx = '0;
    prev = 1'b0;
    check($sformatf("u%0d busy before start", u), busy[u], 0);
    start[u] = 1'b1;
    addr_v[u] = a;
    data_v[u] = d;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      e = model(n, k, g, f);
      check($sformatf("u%0d n%0d ncs", u, n), ncs[u], e[2]);
      check($sformatf("u%0d n%0d sclk", u, n), sclk[u], e[1]);
      check($sformatf("u%0d n%0d busy", u, n), busy[u], e[3]);
      check($sformatf("u%0d n%0d done", u, n), done[u], e[4]);
      if (e[5]) check($sformatf("u%0d n%0d copi", u, n), copi[u], e[0]);
      if (done[u]) begin
        dones++;
        done_at = n;
      end
      if (sclk[u] && !prev) begin
        rises++;
        rx = {rx[14:0], copi[u]};
      end
      prev = sclk[u];
      if (abort_rise > 0 && rises == abort_rise) begin
        rst = 1'b1;
        start[u] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_pins(u, "abort");
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          check($sformatf("u%0d post-abort done c%0d", u, j), done[u], 0);
          check($sformatf("u%0d post-abort ncs c%0d", u, j), ncs[u], 1);
        end
        return;
      end
      if (hold) begin
        start[u] = 1'b1;
      end else if (n == last) begin
        start[u] = 1'b0;
      end else if (noise && n == 20) begin
        start[u] = 1'b1;
        addr_v[u] = 7'h02;
        data_v[u] = 8'hFF;
      end else if (noise) begin
        start[u] = 1'($urandom_range(0, 1));
        addr_v[u] = 7'($urandom);
        data_v[u] = 8'($urandom);
      end else begin
        start[u] = 1'b0;
      end
    end
    check($sformatf("u%0d rising edges", u), rises, 16);
    check($sformatf("u%0d received frame", u), int'(rx), int'(f));
    check($sformatf("u%0d done count", u), dones, 1);
    check($sformatf("u%0d done cycle", u), done_at, last);
    // Peripheral register write: address 0x04 is the PWM duty-cycle register.
    if (rx[15] && rx[14:8] == 7'h04) pwm_duty_cycle = rx[7:0];
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    pwm_duty_cycle = 8'h00;
    rst = 1'b1;
    start = 2'b11;
    for (int u = 0; u < 2; u++) begin
      addr_v[u] = 7'h00;
      data_v[u] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) check_reset_pins(u, "reset");
    rst = 1'b0;
    start = 2'b00;
    @(negedge clk);

    // Basic write; done expected at cycle 137 and PWM register updated.
    run_frame(0, 7'h04, 8'hA5, 1'b0, 1'b0, 0);
    check("pwm_duty_cycle", pwm_duty_cycle, 8'hA5);

    // Start while busy (cycle 20, 0x02/0xFF) plus random input noise must be ignored.
    run_frame(0, 7'h01, 8'h3C, 1'b0, 1'b1, 0);

    // Back-to-back frames with start held high.
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 7'($urandom), 8'($urandom), (i < 2), 1'b0, 0);
    end

    // Abort after the 7th SCLK rise, then a clean frame.
    run_frame(0, 7'($urandom), 8'($urandom), 1'b0, 1'b0, 7);
    run_frame(0, 7'h00, 8'h55, 1'b0, 1'b0, 0);

    // Corner frames and random frames at CLK_DIV=3.
    run_frame(1, 7'h7F, 8'h00, 1'b0, 1'b0, 0);
    run_frame(1, 7'h00, 8'hFF, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      run_frame(1, 7'($urandom), 8'($urandom), 1'b0, 1'b1, 0);
    end

    for (int i = 0; i < 2; i++) begin
      run_frame(0, 7'($urandom), 8'($urandom), 1'b0, 1'b1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
